// File: rtl/iiitb_rv32i_pkg.sv
// iiitb_rv32i_pkg
// Shared definitions for the RV32I core and its instruction-memory loader.
// Provides the IMEM geometry (shared with the core's MEM array) and the
// loader FSM state encoding. Contains no ports.
package iiitb_rv32i_pkg;

  // IMEM geometry: 1024 words of 32 bits, word-addressed like the PC
  localparam int IMEM_DEPTH = 1024;
  localparam int IMEM_AW    = 10;

  // Loader FSM states; CSUM is only reachable in checksum builds
  typedef enum logic [2:0] {
    CNT_LO,
    CNT_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/iiitb_byte_packer.sv
// iiitb_byte_packer
// Assembles little-endian 32-bit words from a byte stream.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (clears lane and partial word)
//   byte_en    in   a byte is being consumed this cycle
//   byte_in    in   byte payload; first byte of a word lands in bits [7:0]
//   word_valid out  high in the cycle the 4th byte of a word is consumed
//   word       out  assembled word, valid while word_valid is high
module iiitb_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [23:0] acc;

  // Lane counter and partial-word storage. The top byte is never stored:
  // it is forwarded straight from byte_in so the word is complete in the
  // same cycle the 4th byte arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane <= 2'd0;
      acc  <= 24'd0;
    end else if (byte_en) begin
      lane <= lane + 2'd1;
      case (lane)
        2'd0:    acc[7:0]   <= byte_in;
        2'd1:    acc[15:8]  <= byte_in;
        2'd2:    acc[23:16] <= byte_in;
        default: acc        <= acc;
      endcase
    end
  end

  assign word_valid = byte_en && (lane == 2'd3);
  assign word       = {byte_in, acc};

endmodule

// File: rtl/iiitb_imem_loader.sv
// iiitb_imem_loader
// Byte-stream program loader for the core's instruction memory. Stream:
// count low byte, count high byte (N words), then N*4 data bytes with each
// word little-endian. Holds the core off until the image is complete.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- a trailing XOR checksum
// byte over all data bytes follows the image; a mismatch ends in ERR.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset, highest priority
//   in_valid   in   source presents a byte
//   in_data    in   byte payload
//   in_ready   out  loader accepts a byte this cycle
//   mem_we     out  one-cycle IMEM write strobe
//   mem_addr   out  IMEM word address
//   mem_wdata  out  instruction word
//   core_hold  out  high until the image is complete
//   load_done  out  image fully written
//   load_err   out  sticky error (oversized image or checksum mismatch)
module iiitb_imem_loader
  import iiitb_rv32i_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = IMEM_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          core_hold,
  output logic          load_done,
  output logic          load_err
);

  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t AFTER_DATA = CSUM;
`else
  localparam loader_state_t AFTER_DATA = DONE;
`endif

  loader_state_t state, state_next;

  logic        accept;
  logic        byte_en;
  logic        word_valid;
  logic [31:0] word;
  logic [7:0]  cnt_lo;
  logic [15:0] n_in;
  logic [AW:0] count;
  logic [AW:0] word_idx;
  logic [AW:0] idx_inc;
  logic        last_word;

  assign accept    = in_valid && in_ready;
  assign byte_en   = accept && (state == DATA);
  assign n_in      = {in_data, cnt_lo};
  assign idx_inc   = word_idx + (AW+1)'(1);
  assign last_word = (idx_inc == count);

  iiitb_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_en    (byte_en),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR over data bytes only; the count bytes never enter it,
  // so an empty image expects 8'h00.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= 8'd0;
    end else if (byte_en) begin
      csum <= csum ^ in_data;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CNT_LO;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      CNT_LO: if (accept) state_next = CNT_HI;
      CNT_HI: begin
        if (accept) begin
          if (n_in > DEPTH16)       state_next = ERR;
          else if (n_in == 16'd0)   state_next = AFTER_DATA;
          else                      state_next = DATA;
        end
      end
      DATA: if (word_valid && last_word) state_next = AFTER_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: if (accept) state_next = (in_data == csum) ? DONE : ERR;
`else
      CSUM: state_next = ERR;
`endif
      DONE:    state_next = DONE;
      ERR:     state_next = ERR;
      default: state_next = ERR;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready  = 1'b0;
    core_hold = 1'b1;
    load_done = 1'b0;
    load_err  = 1'b0;
    case (state)
      CNT_LO, CNT_HI, DATA, CSUM: in_ready = 1'b1;
      DONE: begin
        core_hold = 1'b0;
        load_done = 1'b1;
      end
      ERR:     load_err = 1'b1;
      default: load_err = 1'b1;
    endcase
  end

  // Count capture, word index and registered IMEM write port. The write
  // lands one cycle after the 4th byte; the index advances in the same
  // cycle so the next word can start without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_lo    <= 8'd0;
      count     <= '0;
      word_idx  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
    end else begin
      mem_we <= word_valid;
      if (accept && (state == CNT_LO)) cnt_lo <= in_data;
      if (accept && (state == CNT_HI)) count  <= n_in[AW:0];
      if (word_valid) begin
        mem_addr  <= word_idx[AW-1:0];
        mem_wdata <= word;
        word_idx  <= idx_inc;
      end
    end
  end

endmodule
